// File: rtl/pfpu32_unpack_stage.sv
// pfpu32_unpack_stage: binary32 operand unpack/classify behind a valid/ready register with skid entry
// Ports: clk, rst_n (async, active-low); flush_i drops both entries;
//   in_valid_i/in_ready_o/opa_i/opb_i + compare sideband in;
//   out_valid_o/out_ready_i + per-operand sign/exp10/fract24/snan/qnan/inf/zero + sideband out.
module pfpu32_unpack_stage #(
  parameter int FLUSH_DENORM = 0,
  parameter int OR1K_FPUOP_GENERIC_CMP_WIDTH = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic [31:0]                             opa_i,
  input  logic [31:0]                             opb_i,
  input  logic                                    op_is_comp_i,
  input  logic [OR1K_FPUOP_GENERIC_CMP_WIDTH-1:0] generic_cmp_opc_i,
  input  logic                                    unordered_cmp_bit_i,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic                                    signa_o,
  output logic                                    signb_o,
  output logic [9:0]                              exp10a_o,
  output logic [9:0]                              exp10b_o,
  output logic [23:0]                             fract24a_o,
  output logic [23:0]                             fract24b_o,
  output logic                                    snana_o,
  output logic                                    qnana_o,
  output logic                                    infa_o,
  output logic                                    zeroa_o,
  output logic                                    snanb_o,
  output logic                                    qnanb_o,
  output logic                                    infb_o,
  output logic                                    zerob_o,
  output logic                                    op_is_comp_o,
  output logic [OR1K_FPUOP_GENERIC_CMP_WIDTH-1:0] generic_cmp_opc_o,
  output logic                                    unordered_cmp_bit_o
);
  localparam int PW = OR1K_FPUOP_GENERIC_CMP_WIDTH + 80;
  // {sign, exp10, fract24, snan, qnan, inf, zero}; zero/denormal exponents read as 1
  function automatic logic [38:0] unpack(input logic [31:0] op);
    logic expnz, fnz, emax, den;
    expnz = |op[30:23];
    fnz = |op[22:0];
    emax = &op[30:23];
    den = ~expnz & fnz & (FLUSH_DENORM != 0);
    return {op[31], expnz ? {2'b00, op[30:23]} : 10'd1, den ? 24'd0 : {expnz, op[22:0]},
            emax & fnz & ~op[22], emax & fnz & op[22], emax & ~fnz, ~expnz & (~fnz | den)};
  endfunction
  logic          r_out_vld, r_skid_vld, r_in_ready;
  logic [PW-1:0] r_out, r_skid;
  logic [PW-1:0] w_in;
  logic          w_in_xfer, w_fill_out, w_out_vld_n, w_skid_vld_n, w_out_ld, w_skid_ld;
  assign w_in = {op_is_comp_i, generic_cmp_opc_i, unordered_cmp_bit_i, unpack(opa_i), unpack(opb_i)};
  assign w_in_xfer = in_valid_i & r_in_ready;
  // OUT can take a new item when empty or being drained this cycle
  assign w_fill_out = ~r_out_vld | out_ready_i;
  // skid full implies in_ready low, so skid promotion and input acceptance never coincide
  assign w_out_vld_n = ~flush_i & (w_fill_out ? (r_skid_vld | w_in_xfer) : 1'b1);
  assign w_skid_vld_n = ~flush_i & ~w_fill_out & (r_skid_vld | w_in_xfer);
  assign w_out_ld = w_fill_out & (r_skid_vld | w_in_xfer);
  assign w_skid_ld = ~w_fill_out & w_in_xfer;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
      r_out <= '0;
      r_skid <= '0;
    end else begin
      r_out_vld <= w_out_vld_n;
      r_skid_vld <= w_skid_vld_n;
      r_in_ready <= ~w_skid_vld_n;
      if (w_out_ld) r_out <= r_skid_vld ? r_skid : w_in;
      if (w_skid_ld) r_skid <= w_in;
    end
  end
  assign in_ready_o = r_in_ready;
  assign out_valid_o = r_out_vld;
  assign {op_is_comp_o, generic_cmp_opc_o, unordered_cmp_bit_o,
          signa_o, exp10a_o, fract24a_o, snana_o, qnana_o, infa_o, zeroa_o,
          signb_o, exp10b_o, fract24b_o, snanb_o, qnanb_o, infb_o, zerob_o} = r_out;
endmodule

// File: tb/tb_pfpu32_unpack_stage.sv
// tb_pfpu32_unpack_stage: directed + random check of both FLUSH_DENORM variants against a 2-deep FIFO model
module tb_pfpu32_unpack_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic comp = 1'b0, unord = 1'b0;
  logic [2:0] opc = '0;
  int checks = 0, passed = 0;
  typedef struct packed {logic [31:0] a, b; logic c; logic [2:0] o; logic u;} rec_t;
  rec_t q[$];
  initial forever #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_d
    logic ir, ov, c, u, sa, sb, sna, qna, ia, za, snb, qnb, ib, zb;
    logic [2:0] o;
    logic [9:0] ea, eb;
    logic [23:0] fa, fb;
    pfpu32_unpack_stage #(.FLUSH_DENORM(g), .OR1K_FPUOP_GENERIC_CMP_WIDTH(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir),
      .opa_i(opa), .opb_i(opb), .op_is_comp_i(comp), .generic_cmp_opc_i(opc),
      .unordered_cmp_bit_i(unord), .out_valid_o(ov), .out_ready_i(out_ready),
      .signa_o(sa), .signb_o(sb), .exp10a_o(ea), .exp10b_o(eb), .fract24a_o(fa), .fract24b_o(fb),
      .snana_o(sna), .qnana_o(qna), .infa_o(ia), .zeroa_o(za),
      .snanb_o(snb), .qnanb_o(qnb), .infb_o(ib), .zerob_o(zb),
      .op_is_comp_o(c), .generic_cmp_opc_o(o), .unordered_cmp_bit_o(u));
    wire [82:0] pay = {c, o, u, sa, ea, fa, sna, qna, ia, za, sb, eb, fb, snb, qnb, ib, zb};
  end
  // value-range view of binary32: magnitude below 2^-126 is zero/denormal, above inf pattern is NaN
  function automatic logic [38:0] mdl(input logic [31:0] op, input bit fl);
    int unsigned mag;
    bit den, nan, qn;
    logic [9:0] e;
    logic [23:0] f;
    mag = op & 32'h7fffffff;
    den = mag != 0 && mag < 32'h00800000;
    nan = mag > 32'h7f800000;
    qn = nan && mag >= 32'h7fc00000;
    e = (mag < 32'h00800000) ? 10'd1 : 10'(mag / 32'h00800000);
    f = (den && fl) ? 24'd0 : (mag < 32'h00800000) ? 24'(mag) : 24'((mag % 32'h00800000) + 32'h00800000);
    return {op[31], e, f, nan && !qn, qn, mag == 32'h7f800000, mag == 0 || (den && fl)};
  endfunction
  function automatic logic [82:0] expv(input rec_t r, input bit fl);
    return {r.c, r.o, r.u, mdl(r.a, fl), mdl(r.b, fl)};
  endfunction
  function automatic logic [31:0] rop();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: r[22:0] = '0;
      default: ;
    endcase
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic model_chk();
    chk("out_valid0", g_d[0].ov, q.size() > 0);
    chk("out_valid1", g_d[1].ov, q.size() > 0);
    chk("in_ready0", g_d[0].ir, q.size() < 2);
    chk("in_ready1", g_d[1].ir, q.size() < 2);
    if (q.size() > 0) begin
      chk("payload0", g_d[0].pay, expv(q[0], 1'b0));
      chk("payload1", g_d[1].pay, expv(q[0], 1'b1));
    end
  endtask
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] b, input logic c,
                     input logic [2:0] o, input logic u, input bit rdy, input bit fl);
    bit xin, xout;
    @(negedge clk);
    in_valid = v; opa = a; opb = b; comp = c; opc = o; unord = u; out_ready = rdy; flush = fl;
    xin = v && q.size() < 2;
    xout = q.size() > 0 && rdy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (xout) void'(q.pop_front());
      if (xin) q.push_back('{a: a, b: b, c: c, o: o, u: u});
    end
    #1 model_chk();
  endtask
  initial begin
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k ? g_d[1].ov : g_d[0].ov, 0);
      chk("rst_ready", k ? g_d[1].ir : g_d[0].ir, 1);
      chk("rst_payload", k ? g_d[1].pay : g_d[0].pay, 0);
    end
    rst_n = 1'b1;
    cyc(1, 32'h3F800000, 32'hC0000000, 1, 3'h5, 0, 1, 0);
    chk("norm_a_sign", g_d[0].sa, 0);
    chk("norm_a_exp", g_d[0].ea, 10'h07F);
    chk("norm_a_fract", g_d[0].fa, 24'h800000);
    chk("norm_a_flags", {g_d[0].sna, g_d[0].qna, g_d[0].ia, g_d[0].za}, 0);
    chk("norm_b_sign", g_d[0].sb, 1);
    chk("norm_b_exp", g_d[0].eb, 10'h080);
    chk("norm_b_fract", g_d[0].fb, 24'h800000);
    cyc(1, 32'h7F800001, 32'h7FC00000, 0, 3'h1, 1, 1, 0);
    chk("snan_a", g_d[0].sna, 1);
    chk("qnan_b", g_d[0].qnb, 1);
    cyc(1, 32'hFF800000, 32'h80000000, 0, 3'h2, 0, 1, 0);
    chk("inf_a", {g_d[0].ia, g_d[0].sa}, 2'b11);
    chk("zero_b", {g_d[0].zb, g_d[0].sb, g_d[0].eb, g_d[0].fb}, {2'b11, 10'd1, 24'd0});
    cyc(1, 32'h00000001, 32'h00000001, 0, 3'h3, 0, 1, 0);
    chk("denorm_keep", {g_d[0].ea, g_d[0].fa, g_d[0].za}, {10'd1, 24'h000001, 1'b0});
    chk("denorm_flush", {g_d[1].ea, g_d[1].fa, g_d[1].za}, {10'd1, 24'h000000, 1'b1});
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 32'h3F800000, 32'h40000000, 1, 3'h1, 0, 0, 0);
    cyc(1, 32'h40400000, 32'h40800000, 0, 3'h2, 1, 0, 0);
    chk("bp_full_ready", g_d[0].ir, 0);
    cyc(1, 32'h40A00000, 32'h40C00000, 1, 3'h3, 1, 0, 0);
    cyc(1, 32'h40A00000, 32'h40C00000, 1, 3'h3, 1, 1, 0);
    chk("bp_second_opc", g_d[0].o, 3'h2);
    cyc(1, 32'h40A00000, 32'h40C00000, 1, 3'h3, 1, 1, 0);
    chk("bp_third_opc", g_d[0].o, 3'h3);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 32'h3F800000, 32'h3F800000, 0, 3'h4, 0, 0, 0);
    cyc(1, 32'h40000000, 32'h40000000, 0, 3'h5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("flush_valid", g_d[0].ov, 0);
    chk("flush_ready", g_d[0].ir, 1);
    cyc(1, 32'h3F800000, 32'h3F800000, 0, 3'h4, 0, 0, 0);
    cyc(1, 32'h7FC00000, 32'h7FC00000, 1, 3'h7, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_drop", g_d[0].ov, 0);
    cyc(1, 32'h3F800000, 32'h3F800000, 0, 3'h4, 0, 0, 0);
    cyc(1, 32'h40000000, 32'h40000000, 0, 3'h5, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", g_d[0].ov, 0);
    chk("arst_ready", g_d[0].ir, 1);
    chk("arst_payload", g_d[1].pay, 0);
    q.delete();
    #1 rst_n = 1'b1;
    cyc(1, 32'h3F800000, 32'h40400000, 1, 3'h6, 0, 1, 0);
    chk("post_rst_exp_b", g_d[0].eb, 10'h080);
    chk("post_rst_fract_b", g_d[0].fb, 24'hC00000);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, rop(), rop(), 1'($urandom), 3'($urandom), 1'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
